// File: rtl/ifetch_unit.sv
// Multicycle instruction-fetch stage: fetches one word per FETCH/ISSUE round trip,
// holds it for the decoder, and selects the next PC from the decoder/ALU outputs.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 14
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              Branch,
    input  logic              nBranch,
    input  logic              Jmp,
    input  logic              Jal,
    input  logic              Jrn,
    input  logic              Zero,
    input  logic [31:0]       Add_result,
    input  logic [31:0]       Read_data_1,
    output logic [31:0]       Instruction,
    output logic [5:0]        Opcode,
    output logic [5:0]        Function_opcode,
    output logic              instr_valid,
    output logic [31:0]       pc,
    output logic [31:0]       PC_plus_4,
    output logic [31:0]       link_addr,
    output logic              fetch_err,
    output logic              fsm_state
);

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] jump_target;
    logic [31:0] next_pc;
    logic        branch_taken;
    logic        misaligned;

    assign PC_plus_4       = pc + 32'd4;
    assign Opcode          = Instruction[31:26];
    assign Function_opcode = Instruction[5:0];
    assign imem_addr       = pc[ADDR_W+1:2];
    assign fsm_state       = state;

    // Gated by reset so no request is visible while reset is held.
    assign imem_req    = reset && (state == FETCH);
    assign instr_valid = reset && (state == ISSUE);

    assign jump_target  = {PC_plus_4[31:28], Instruction[25:0], 2'b00};
    assign branch_taken = (Branch && Zero) || (nBranch && !Zero);

    always_comb begin
        next_pc = PC_plus_4;
        if (Jrn)
            next_pc = Read_data_1;
        else if (Jmp || Jal)
            next_pc = jump_target;
        else if (branch_taken)
            next_pc = Add_result;
    end

    assign misaligned = |next_pc[1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            Instruction <= '0;
            link_addr   <= '0;
            fetch_err   <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        Instruction <= imem_rdata;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        // Misaligned targets are truncated to a word boundary and flagged.
                        pc <= {next_pc[31:2], 2'b00};
                        if (misaligned)
                            fetch_err <= 1'b1;
                        if (Jal)
                            link_addr <= PC_plus_4;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a ROM/decoder driver walks a hand-computed program path,
// and a monitor compares every fetch address and every issued instruction against queues.
module tb_ifetch_unit;

    localparam int ADDR_W = 14;
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_JR   = 5'b10000;
    localparam logic [4:0] C_J    = 5'b01000;
    localparam logic [4:0] C_JAL  = 5'b00100;
    localparam logic [4:0] C_BEQ  = 5'b00010;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready = 1'b0;
    logic [31:0]       imem_rdata = '0;
    logic              stall = 1'b0;
    logic              Branch = 1'b0, nBranch = 1'b0, Jmp = 1'b0, Jal = 1'b0, Jrn = 1'b0;
    logic              Zero = 1'b0;
    logic [31:0]       Add_result = '0;
    logic [31:0]       Read_data_1 = '0;
    logic [31:0]       Instruction;
    logic [5:0]        Opcode;
    logic [5:0]        Function_opcode;
    logic              instr_valid;
    logic [31:0]       pc;
    logic [31:0]       PC_plus_4;
    logic [31:0]       link_addr;
    logic              fetch_err;
    logic              fsm_state;

    int n_vec = 0;
    int n_bad = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [63:0]       exp_q[$];

    ifetch_unit #(.RESET_PC(32'h0), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall),
        .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jrn(Jrn),
        .Zero(Zero), .Add_result(Add_result), .Read_data_1(Read_data_1),
        .Instruction(Instruction), .Opcode(Opcode), .Function_opcode(Function_opcode),
        .instr_valid(instr_valid), .pc(pc), .PC_plus_4(PC_plus_4),
        .link_addr(link_addr), .fetch_err(fetch_err), .fsm_state(fsm_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic prev_valid;
        logic [63:0] rec;
        prev_valid = 1'b0;
        forever begin
            @(negedge clock);
            if (imem_req && imem_ready) begin
                if (exp_addr_q.size() == 0)
                    check("unexpected_fetch", 32'(imem_addr), 32'hFFFF_FFFF);
                else
                    check("imem_addr", 32'(imem_addr), 32'(exp_addr_q.pop_front()));
            end
            if (instr_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", pc, 32'hFFFF_FFFF);
                end else begin
                    rec = exp_q.pop_front();
                    check("issue_pc", pc, rec[63:32]);
                    check("issue_instr", Instruction, rec[31:0]);
                    check("issue_opcode", 32'(Opcode), 32'(rec[31:26]));
                    check("issue_funct", 32'(Function_opcode), 32'(rec[5:0]));
                end
            end
            prev_valid = instr_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_req();
        int i;
        for (i = 0; i < 20 && !imem_req; i++) begin
            @(posedge clock); #1;
        end
        if (!imem_req)
            check("req_timeout", 32'(imem_req), 32'h1);
    endtask

    // One instruction: ROM answers after 'delay' cycles, decoder drives 'ctl' during ISSUE.
    task automatic issue(input logic [31:0] addr, input logic [31:0] word, input int delay,
                         input int stall_cyc, input logic [4:0] ctl, input logic zero,
                         input logic [31:0] add_res, input logic [31:0] rd1);
        logic [31:0] addr_p4;
        addr_p4 = addr + 32'd4;
        exp_addr_q.push_back(addr[ADDR_W+1:2]);
        exp_q.push_back({addr, word});
        wait_req();
        repeat (delay) begin
            @(posedge clock); #1;
            check("req_held", 32'(imem_req), 32'h1);
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        @(posedge clock); #1;
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        check("valid_in_issue", 32'(instr_valid), 32'h1);
        check("pc_plus_4", PC_plus_4, addr_p4);
        {Jrn, Jmp, Jal, Branch, nBranch} = ctl;
        Zero = zero;
        Add_result = add_res;
        Read_data_1 = rd1;
        stall = (stall_cyc > 0);
        for (int s = 0; s < stall_cyc; s++) begin
            @(posedge clock); #1;
            check("stall_instr", Instruction, word);
            check("stall_pc", pc, addr);
            check("stall_no_req", 32'(imem_req), 32'h0);
        end
        stall = 1'b0;
        @(posedge clock); #1;
        {Jrn, Jmp, Jal, Branch, nBranch} = C_NONE;
        Zero = 1'b0;
        Add_result = $urandom;
        Read_data_1 = $urandom;
    endtask

    task automatic check_reset_values();
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", Instruction, 32'h0);
        check("rst_link", link_addr, 32'h0);
        check("rst_err", 32'(fetch_err), 32'h0);
        check("rst_state", 32'(fsm_state), 32'h0);
    endtask

    // ---------------- directed program ----------------
    initial begin
        repeat (2) @(posedge clock);
        #1;
        check_reset_values();
        check("rst_pc_plus_4", PC_plus_4, 32'h4);
        reset = 1'b1;

        // straight-line code
        issue(32'h0000_0000, 32'h2000_0001, 0, 0, C_NONE, 1'b0, 32'h0, 32'h0);
        issue(32'h0000_0004, 32'h0000_0020, 0, 0, C_NONE, 1'b0, 32'h0, 32'h0);
        // beq taken to 0x40, then beq not taken
        issue(32'h0000_0008, 32'h1000_0005, 0, 0, C_BEQ, 1'b1, 32'h40, 32'h0);
        issue(32'h0000_0040, 32'h1000_0010, 0, 0, C_BEQ, 1'b0, 32'h80, 32'h0);
        // j 0x100
        issue(32'h0000_0044, 32'h0800_0040, 0, 0, C_J, 1'b0, 32'h0, 32'h0);
        // jal at 0x100, target field 0x20 -> 0x80
        issue(32'h0000_0100, 32'h0C00_0020, 0, 0, C_JAL, 1'b0, 32'h0, 32'h0);
        check("jal_link", link_addr, 32'h104);
        check("jal_pc", pc, 32'h80);
        // jr back to link address
        issue(32'h0000_0080, 32'h03E0_0008, 0, 0, C_JR, 1'b0, 32'h0, 32'h104);
        check("jr_pc", pc, 32'h104);
        check("link_held", link_addr, 32'h104);
        // slow ROM and stalled ISSUE
        issue(32'h0000_0104, 32'h0123_4567, 3, 2, C_NONE, 1'b0, 32'h0, 32'h0);
        check("no_err_yet", 32'(fetch_err), 32'h0);
        // misaligned jr target 0x42 -> 0x40, sticky error
        issue(32'h0000_0108, 32'h0060_0008, 0, 0, C_JR, 1'b0, 32'h0, 32'h42);
        check("misalign_pc", pc, 32'h40);
        check("misalign_err", 32'(fetch_err), 32'h1);
        // Jrn outranks Jmp
        issue(32'h0000_0040, 32'hDEAD_BEEF, 0, 0, C_JR | C_J, 1'b0, 32'h0, 32'h200);
        check("err_sticky", 32'(fetch_err), 32'h1);
        // jump to the top word, then wrap to 0
        issue(32'h0000_0200, 32'h03E0_0008, 0, 0, C_JR, 1'b0, 32'h0, 32'hFFFF_FFFC);
        issue(32'hFFFF_FFFC, 32'h0000_0000, 1, 0, C_NONE, 1'b0, 32'h0, 32'h0);
        check("wrap_pc", pc, 32'h0);
        issue(32'h0000_0000, 32'h8C22_0004, 0, 0, C_NONE, 1'b0, 32'h0, 32'h0);

        // reset in the middle of fetching address 4
        wait_req();
        check("pre_reset_pc", pc, 32'h4);
        repeat (2) begin
            @(posedge clock); #1;
        end
        reset = 1'b0;
        #1;
        check_reset_values();
        imem_ready = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        @(posedge clock); #1;
        check("rst_no_capture", Instruction, 32'h0);
        check("rst_no_valid", 32'(instr_valid), 32'h0);
        imem_ready = 1'b0;
        reset = 1'b1;

        issue(32'h0000_0000, 32'h1234_5678, 0, 0, C_NONE, 1'b0, 32'h0, 32'h0);

        repeat (3) @(posedge clock);
        #1;
        check("addr_q_drained", 32'(exp_addr_q.size()), 32'h0);
        check("issue_q_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
